vga_timing_gen: RTL and testbench

- Parametrised successor to the fixed 800x600 VGA sync block. Generates pixel-clock-enable, hsync/vsync/data-enable and pixel coordinates for any mode set by parameters.
- Adds a lookahead fetch coordinate stream so the PPU pipeline can prefetch pixel data LOOKAHEAD pixels ahead of the visible beam.
- Adds line_start, frame_start and vblank strobes for PPU/CPU synchronisation.
- Runs in the system clock domain, using a clock-enable in place of a divided clock.

---
 rtl/vga_timing_gen.sv | 148 ++++++++++++++
 tb/tb_vga_timing_gen.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing: pixel-clock enable, syncs, DE, display/fetch coordinates, sync strobes.
// Latency: all decoded outputs are registered and change together on the pixel tick; pix_ce is one clk wide.
// Backpressure: none, free-running once out of reset.
module vga_timing_gen #(
    parameter int   H_DISPLAY = 800,
    parameter int   H_FRONT   = 56,
    parameter int   H_SYNC    = 120,
    parameter int   H_BACK    = 64,
    parameter int   V_DISPLAY = 600,
    parameter int   V_FRONT   = 37,
    parameter int   V_SYNC    = 6,
    parameter int   V_BACK    = 23,
    parameter logic HS_POL    = 1'b1,
    parameter logic VS_POL    = 1'b1,
    parameter int   CLK_DIV   = 2,
    parameter int   LOOKAHEAD = 0,
    parameter int   XW        = 11,
    parameter int   YW        = 10
) (
    input  logic          clk,
    input  logic          rst,
    output logic          pix_ce,
    output logic          hsync,
    output logic          vsync,
    output logic          de,
    output logic [XW-1:0] pix_x,
    output logic [YW-1:0] pix_y,
    output logic [XW-1:0] fetch_x,
    output logic [YW-1:0] fetch_y,
    output logic          fetch_active,
    output logic          line_start,
    output logic          frame_start,
    output logic          vblank
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [XW-1:0] H_LAST  = XW'(H_TOTAL - 1);
    localparam logic [YW-1:0] V_LAST  = YW'(V_TOTAL - 1);
    localparam logic [XW-1:0] H_VIS   = XW'(H_DISPLAY);
    localparam logic [YW-1:0] V_VIS   = YW'(V_DISPLAY);
    localparam logic [XW-1:0] HS_BEG  = XW'(H_DISPLAY + H_FRONT);
    localparam logic [XW-1:0] HS_END  = XW'(H_DISPLAY + H_FRONT + H_SYNC);
    localparam logic [YW-1:0] VS_BEG  = YW'(V_DISPLAY + V_FRONT);
    localparam logic [YW-1:0] VS_END  = YW'(V_DISPLAY + V_FRONT + V_SYNC);
    localparam logic [XW-1:0] DX_RST  = (LOOKAHEAD == 0) ? '0 : XW'(H_TOTAL - LOOKAHEAD);
    localparam logic [YW-1:0] DY_RST  = (LOOKAHEAD == 0) ? '0 : YW'(V_TOTAL - 1);
    localparam logic [DW-1:0] DIV_END = DW'(CLK_DIV - 1);

    if (H_TOTAL >= (1 << XW) || V_TOTAL >= (1 << YW)) begin : g_bad_width
        $error("vga_timing_gen: H_TOTAL/V_TOTAL do not fit in XW/YW");
    end
    if (H_FRONT < 1 || H_BACK < 1 || V_FRONT < 1 || V_BACK < 1 || CLK_DIV < 1) begin : g_bad_timing
        $error("vga_timing_gen: porches and CLK_DIV must be >= 1");
    end
    if (LOOKAHEAD < 0 || LOOKAHEAD > H_DISPLAY) begin : g_bad_lookahead
        $error("vga_timing_gen: LOOKAHEAD out of range");
    end

    logic [DW-1:0] div_cnt;
    logic          running;
    logic [XW-1:0] fx, dx, fx_n, dx_n;
    logic [YW-1:0] fy, dy, fy_n, dy_n;
    logic          hs_act, vs_act, de_n, fa_n, ls_n, fs_n, vb_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
            pix_ce  <= 1'b0;
        end else if (div_cnt == DIV_END) begin
            div_cnt <= '0;
            pix_ce  <= 1'b1;
        end else begin
            div_cnt <= div_cnt + 1'b1;
            pix_ce  <= 1'b0;
        end
    end

    // The first tick after reset presents the reset position itself, so the
    // first line/frame strobes are not skipped.
    always_comb begin
        fx_n = fx;
        fy_n = fy;
        dx_n = dx;
        dy_n = dy;
        if (running) begin
            fx_n = (fx == H_LAST) ? '0 : fx + 1'b1;
            dx_n = (dx == H_LAST) ? '0 : dx + 1'b1;
            if (fx == H_LAST) begin
                fy_n = (fy == V_LAST) ? '0 : fy + 1'b1;
            end
            if (dx == H_LAST) begin
                dy_n = (dy == V_LAST) ? '0 : dy + 1'b1;
            end
        end
    end

    always_comb begin
        hs_act = (dx_n >= HS_BEG) && (dx_n < HS_END);
        vs_act = (dy_n >= VS_BEG) && (dy_n < VS_END);
        de_n   = (dx_n < H_VIS) && (dy_n < V_VIS);
        fa_n   = (fx_n < H_VIS) && (fy_n < V_VIS);
        ls_n   = (dx_n == '0) && (dy_n < V_VIS);
        fs_n   = (dx_n == '0) && (dy_n == '0);
        vb_n   = (dy_n >= V_VIS);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            running      <= 1'b0;
            fx           <= '0;
            fy           <= '0;
            dx           <= DX_RST;
            dy           <= DY_RST;
            hsync        <= ~HS_POL;
            vsync        <= ~VS_POL;
            de           <= 1'b0;
            pix_x        <= '0;
            pix_y        <= '0;
            fetch_x      <= '0;
            fetch_y      <= '0;
            fetch_active <= 1'b0;
            line_start   <= 1'b0;
            frame_start  <= 1'b0;
            vblank       <= 1'b0;
        end else if (pix_ce) begin
            running      <= 1'b1;
            fx           <= fx_n;
            fy           <= fy_n;
            dx           <= dx_n;
            dy           <= dy_n;
            hsync        <= hs_act ? HS_POL : ~HS_POL;
            vsync        <= vs_act ? VS_POL : ~VS_POL;
            de           <= de_n;
            pix_x        <= dx_n;
            pix_y        <= dy_n;
            fetch_x      <= fx_n;
            fetch_y      <= fy_n;
            fetch_active <= fa_n;
            line_start   <= ls_n;
            frame_start  <= fs_n;
            vblank       <= vb_n;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: four parameterisations share clk/rst, each checked every clk against
// a position-arithmetic model driven by the number of clk edges since reset.
module tb_vga_timing_gen;

    typedef struct packed {
        int hd, hf, hs, hb, vd, vf, vs, vb, hp, vp, div, la;
    } mode_t;

    typedef struct packed {
        logic        ce, hs, vs, de, fa, ls, fs, vb;
        logic [31:0] px, py, fx, fy;
    } obs_t;

    localparam mode_t M_DEF   = '{800, 56, 120, 64, 600, 37, 6, 23, 1, 1, 2, 0};
    localparam mode_t M_LA    = '{800, 56, 120, 64, 600, 37, 6, 23, 1, 1, 2, 4};
    localparam mode_t M_SMALL = '{8, 1, 2, 1, 4, 1, 1, 1, 1, 1, 1, 0};
    localparam mode_t M_POL   = '{8, 1, 2, 1, 4, 1, 1, 1, 0, 0, 3, 3};

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   e_cnt = -1;
    int   n_total = 0;
    int   n_pass = 0;

    logic [3:0]  ce, hs, vs, de, fa, ls, fs, vb;
    logic [10:0] px [4];
    logic [10:0] fx [4];
    logic [9:0]  py [4];
    logic [9:0]  fy [4];

    always #5 clk = ~clk;

    vga_timing_gen #(
        .H_DISPLAY(M_DEF.hd), .H_FRONT(M_DEF.hf), .H_SYNC(M_DEF.hs), .H_BACK(M_DEF.hb),
        .V_DISPLAY(M_DEF.vd), .V_FRONT(M_DEF.vf), .V_SYNC(M_DEF.vs), .V_BACK(M_DEF.vb),
        .HS_POL(1'b1), .VS_POL(1'b1), .CLK_DIV(M_DEF.div), .LOOKAHEAD(M_DEF.la), .XW(11), .YW(10)
    ) u_def (
        .clk(clk), .rst(rst), .pix_ce(ce[0]), .hsync(hs[0]), .vsync(vs[0]), .de(de[0]),
        .pix_x(px[0]), .pix_y(py[0]), .fetch_x(fx[0]), .fetch_y(fy[0]), .fetch_active(fa[0]),
        .line_start(ls[0]), .frame_start(fs[0]), .vblank(vb[0])
    );

    vga_timing_gen #(
        .H_DISPLAY(M_LA.hd), .H_FRONT(M_LA.hf), .H_SYNC(M_LA.hs), .H_BACK(M_LA.hb),
        .V_DISPLAY(M_LA.vd), .V_FRONT(M_LA.vf), .V_SYNC(M_LA.vs), .V_BACK(M_LA.vb),
        .HS_POL(1'b1), .VS_POL(1'b1), .CLK_DIV(M_LA.div), .LOOKAHEAD(M_LA.la), .XW(11), .YW(10)
    ) u_la (
        .clk(clk), .rst(rst), .pix_ce(ce[1]), .hsync(hs[1]), .vsync(vs[1]), .de(de[1]),
        .pix_x(px[1]), .pix_y(py[1]), .fetch_x(fx[1]), .fetch_y(fy[1]), .fetch_active(fa[1]),
        .line_start(ls[1]), .frame_start(fs[1]), .vblank(vb[1])
    );

    vga_timing_gen #(
        .H_DISPLAY(M_SMALL.hd), .H_FRONT(M_SMALL.hf), .H_SYNC(M_SMALL.hs), .H_BACK(M_SMALL.hb),
        .V_DISPLAY(M_SMALL.vd), .V_FRONT(M_SMALL.vf), .V_SYNC(M_SMALL.vs), .V_BACK(M_SMALL.vb),
        .HS_POL(1'b1), .VS_POL(1'b1), .CLK_DIV(M_SMALL.div), .LOOKAHEAD(M_SMALL.la), .XW(11), .YW(10)
    ) u_small (
        .clk(clk), .rst(rst), .pix_ce(ce[2]), .hsync(hs[2]), .vsync(vs[2]), .de(de[2]),
        .pix_x(px[2]), .pix_y(py[2]), .fetch_x(fx[2]), .fetch_y(fy[2]), .fetch_active(fa[2]),
        .line_start(ls[2]), .frame_start(fs[2]), .vblank(vb[2])
    );

    vga_timing_gen #(
        .H_DISPLAY(M_POL.hd), .H_FRONT(M_POL.hf), .H_SYNC(M_POL.hs), .H_BACK(M_POL.hb),
        .V_DISPLAY(M_POL.vd), .V_FRONT(M_POL.vf), .V_SYNC(M_POL.vs), .V_BACK(M_POL.vb),
        .HS_POL(1'b0), .VS_POL(1'b0), .CLK_DIV(M_POL.div), .LOOKAHEAD(M_POL.la), .XW(11), .YW(10)
    ) u_pol (
        .clk(clk), .rst(rst), .pix_ce(ce[3]), .hsync(hs[3]), .vsync(vs[3]), .de(de[3]),
        .pix_x(px[3]), .pix_y(py[3]), .fetch_x(fx[3]), .fetch_y(fy[3]), .fetch_active(fa[3]),
        .line_start(ls[3]), .frame_start(fs[3]), .vblank(vb[3])
    );

    function automatic mode_t get_mode(input int i);
        case (i)
            0:       return M_DEF;
            1:       return M_LA;
            2:       return M_SMALL;
            default: return M_POL;
        endcase
    endfunction

    // Tick t (t>=1) lands on clk edge CLK_DIV*t+1 after reset; tick 1 shows the reset position,
    // so the fetch position is simply (ticks-1) mod frame and display trails it by LOOKAHEAD.
    function automatic obs_t model(input int e, input mode_t m);
        obs_t r;
        int ht, vt, f, ticks, p, d, dx, dy;
        ht = m.hd + m.hf + m.hs + m.hb;
        vt = m.vd + m.vf + m.vs + m.vb;
        f  = ht * vt;
        r  = '0;
        r.ce = (e >= 1) && (e % m.div == 0);
        ticks = (e >= 1) ? (e - 1) / m.div : 0;
        r.hs = (m.hp == 0);
        r.vs = (m.vp == 0);
        if (ticks > 0) begin
            p  = (ticks - 1) % f;
            d  = ((p - m.la) % f + f) % f;
            dx = d % ht;
            dy = d / ht;
            r.px = dx;
            r.py = dy;
            r.fx = p % ht;
            r.fy = p / ht;
            r.de = (dx < m.hd) && (dy < m.vd);
            r.fa = ((p % ht) < m.hd) && ((p / ht) < m.vd);
            r.hs = ((dx >= m.hd + m.hf) && (dx < m.hd + m.hf + m.hs)) ? (m.hp != 0) : (m.hp == 0);
            r.vs = ((dy >= m.vd + m.vf) && (dy < m.vd + m.vf + m.vs)) ? (m.vp != 0) : (m.vp == 0);
            r.ls = (dx == 0) && (dy < m.vd);
            r.fs = (dx == 0) && (dy == 0);
            r.vb = (dy >= m.vd);
        end
        return r;
    endfunction

    always @(posedge clk) begin
        if (rst) e_cnt = 0;
        else if (e_cnt >= 0) e_cnt = e_cnt + 1;
    end

    always @(negedge clk) begin
        if (e_cnt >= 0) begin
            for (int i = 0; i < 4; i++) begin
                obs_t got, want;
                got.ce = ce[i]; got.hs = hs[i]; got.vs = vs[i]; got.de = de[i];
                got.fa = fa[i]; got.ls = ls[i]; got.fs = fs[i]; got.vb = vb[i];
                got.px = {21'b0, px[i]}; got.py = {22'b0, py[i]};
                got.fx = {21'b0, fx[i]}; got.fy = {22'b0, fy[i]};
                want = model(e_cnt, get_mode(i));
                n_total++;
                if (got === want) n_pass++;
                else $display("FAIL model_dut%0d e=%0d got ce%b hs%b vs%b de%b fa%b ls%b fs%b vb%b xy %0d,%0d f %0d,%0d required ce%b hs%b vs%b de%b fa%b ls%b fs%b vb%b xy %0d,%0d f %0d,%0d",
                    i, e_cnt, got.ce, got.hs, got.vs, got.de, got.fa, got.ls, got.fs, got.vb,
                    got.px, got.py, got.fx, got.fy, want.ce, want.hs, want.vs, want.de, want.fa,
                    want.ls, want.fs, want.vb, want.px, want.py, want.fx, want.fy);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got === want) n_pass++;
        else $display("FAIL %s got %0d required %0d", name, got, want);
    endtask

    task automatic wait_px0(input int x, output bit ok);
        int n = 0;
        while (px[0] !== 11'(x) && n < 6000) begin
            @(negedge clk);
            n++;
        end
        ok = (n < 6000);
    endtask

    initial begin
        bit ok;
        int n_ls, n_hs, n_vb, n_fs;

        repeat (3) @(negedge clk);
        chk("rst_def_hsync", hs[0], 0);
        chk("rst_def_vsync", vs[0], 0);
        chk("rst_def_de", de[0], 0);
        chk("rst_pol_hsync", hs[3], 1);
        chk("rst_pol_vsync", vs[3], 1);
        rst = 1'b0;

        @(negedge clk);
        chk("ce_def_clk1", ce[0], 0);
        chk("ce_small_clk1", ce[2], 1);
        @(negedge clk);
        chk("ce_def_clk2", ce[0], 1);
        @(negedge clk);
        chk("la_first_px", px[1], 1036);
        chk("la_first_py", py[1], 665);
        chk("la_first_fx", fx[1], 0);

        wait_px0(400, ok);
        chk("wait_px400", ok, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_px", px[0], 0);
        chk("midrst_de", de[0], 0);
        chk("midrst_ce", ce[0], 0);

        repeat (10) @(negedge clk);
        n_ls = 0; n_hs = 0; n_vb = 0; n_fs = 0;
        for (int i = 0; i < 84; i++) begin
            n_ls += int'(ls[2]);
            n_hs += int'(hs[2]);
            n_vb += int'(vb[2]);
            n_fs += int'(fs[2]);
            @(negedge clk);
        end
        chk("small_line_starts", n_ls, 4);
        chk("small_hsync_ticks", n_hs, 14);
        chk("small_vblank_ticks", n_vb, 36);
        chk("small_frame_starts", n_fs, 1);

        wait_px0(855, ok);
        chk("wait_px855", ok, 1);
        chk("hs_at_855", hs[0], 0);
        wait_px0(856, ok);
        chk("hs_at_856", hs[0], 1);
        wait_px0(975, ok);
        chk("hs_at_975", hs[0], 1);
        wait_px0(976, ok);
        chk("hs_at_976", hs[0], 0);

        for (int k = 0; k < 6; k++) begin
            repeat ($urandom_range(20, 2500)) @(negedge clk);
            rst = 1'b1;
            repeat ($urandom_range(1, 3)) @(negedge clk);
            rst = 1'b0;
        end
        repeat (3000) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
